cpu_if_fetch: RTL and testbench
===============================

# cpu_if_fetch

Instruction-fetch stage of the TrivialMIPS pipeline. It sits directly upstream of the decode stage. It owns the program counter, issues split-transaction requests to instruction memory, and buffers returned instructions in a small FIFO. Decode consumes them as {pc, inst} pairs, can stall the stage, and on branch resolution can flush it and redirect the PC.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000: PC value loaded on reset.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  decode/pipeline hold; the FIFO head is not consumed while high.
- flush  in  1  branch/jump redirect strobe.
- redirect_pc  in  32  new fetch address, sampled when flush=1.
- imem_req  out  1  address request valid.
- imem_addr  out  32  fetch address.
- imem_gnt  in  1  request accepted when imem_req&imem_gnt.
- imem_rvalid  in  1  read data valid; responses are in order, at most one outstanding.
- imem_rdata  in  32  instruction word.
- valid_o  out  1  FIFO head valid.
- pc_o  out  32  PC of the head entry.
- inst_o  out  32  instruction of the head entry; 32'h0 when valid_o=0.
- addr_err_o  out  1  head entry carries an instruction-address error.

## Operation
- State machine:
  - IDLE: no request in flight.
  - REQ: imem_req=1, address held.
  - WAIT: granted, awaiting rvalid.
  - DROP: awaiting a stale response to discard.
  - HALT: only with CPU_IF_ALIGN_CHECK_EN.
- IDLE→REQ when occupancy < FIFO_DEPTH, where occupancy = FIFO count plus one if a request is in flight.
- REQ→WAIT on gnt. imem_addr and imem_req stay stable until gnt.
- WAIT→IDLE on rvalid. In that cycle, push {pc_fetch, imem_rdata} and set pc_fetch += 4 (32-bit wrap, no carry out).
- Pop: the head is consumed on a cycle where valid_o=1 and stall=0. Push and pop in the same cycle are legal at any count.
- Flush, highest priority:
  - FIFO cleared; valid_o=0 next cycle; pc_fetch<=redirect_pc.
  - From WAIT, or from REQ with gnt in the same cycle, go to DROP. Otherwise go to IDLE.
  - Flush in the same cycle as rvalid drops that data and goes to IDLE.
- DROP→IDLE on rvalid, with data discarded and no push. A flush while in DROP only updates pc_fetch.
- Flush overrides stall.
- Reset values:
  - pc_fetch=RESET_PC, state IDLE, FIFO empty.
  - imem_req=0, imem_addr=RESET_PC.
  - valid_o=0, pc_o=0, inst_o=0, addr_err_o=0.
- Reset mid-transaction abandons the outstanding request. The memory side is reset by the same rst.

## Timing
- Registered outputs are imem_req and imem_addr. valid_o, pc_o and inst_o come combinationally from the FIFO head registers.
- First request is issued in the cycle after rst deasserts.
- Best-case fill latency: gnt in cycle t, rvalid in t+1, valid_o=1 in t+2.
- Sustained throughput is one instruction per 2 cycles, because only one request may be outstanding. No comb path from imem_rdata to inst_o.
- The stall→imem_req path is registered via the occupancy check.

## Configuration
- CPU_IF_ALIGN_CHECK_EN defined:
  - Entering REQ with pc_fetch[1:0]≠0 issues no memory request.
  - Instead, push {pc_fetch, 32'h0} with addr_err_o=1 and enter HALT.
  - HALT is left only by flush or rst.
- Undefined:
  - imem_addr[1:0] forced to 2'b00 and pc_fetch[1:0] ignored.
  - addr_err_o tied to 0, no HALT state.

## Structure
- Shared package cpu_defs: typedef IfEntry_t {InstAddr_t pc; Inst_t inst; Bit_t addr_err}, enum IfState_t, and constant RESET_PC_DEFAULT.
- One sub-module, if_inst_fifo: a parameterised sync FIFO of IfEntry_t with push, pop, clear, count, full, empty and head. Clear has priority over push.

## Test plan
- Reset, then gnt immediately and rvalid 1 cycle later with rdata=32'h2408_0001 → imem_addr=BFC00000, then BFC00004; valid_o rises with pc_o=BFC00000, inst_o=24080001.
- stall held for 10 cycles with zero-latency memory → exactly 2 entries buffered, imem_req stays 0, and no data is lost after release (pc_o sequence +4).
- flush with redirect_pc=80000100 while in WAIT, then rvalid with 32'hDEAD_BEEF → no push of DEADBEEF; next request at 80000100.
- flush in the same cycle as rvalid and a pop while stall=1 → FIFO empty next cycle, valid_o=0, and no stale entry delivered.
- PC 32'hFFFF_FFFC fetched → next imem_addr=00000000.
- With CPU_IF_ALIGN_CHECK_EN, redirect_pc=80000102 → imem_req never asserts, head pc_o=80000102 with addr_err_o=1, and imem_req stays 0 until the next flush.

Source files
------------

// File: rtl/cpu_if_fetch_pkg.sv
// Shared TrivialMIPS fetch-stage types: buffer entry layout, fetch FSM states
// and the default reset vector. HALT exists only when CPU_IF_ALIGN_CHECK_EN
// is defined.
package cpu_defs;

  typedef logic [31:0] InstAddr_t;
  typedef logic [31:0] Inst_t;
  typedef logic        Bit_t;

  typedef struct packed {
    InstAddr_t pc;
    Inst_t     inst;
    Bit_t      addr_err;
  } IfEntry_t;

  typedef enum logic [2:0] {
    IF_IDLE = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    IF_DROP = 3'd3
`ifdef CPU_IF_ALIGN_CHECK_EN
    ,
    IF_HALT = 3'd4
`endif
  } IfState_t;

  localparam InstAddr_t RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Sequential fetch address; wraps at 32 bits with no carry out.
  function automatic InstAddr_t pc_next(input InstAddr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/cpu_if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction
// memory (slave). Split transaction, in-order, at most one outstanding.
interface cpu_if_fetch_if;
  import cpu_defs::*;

  logic      imem_req;
  InstAddr_t imem_addr;
  logic      imem_gnt;
  logic      imem_rvalid;
  Inst_t     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/cpu_if_fetch_fifo.sv
// if_inst_fifo: small synchronous FIFO of fetched {pc, inst, addr_err}
// entries. The head is read straight from the storage registers so decode
// sees it without a read-latency cycle. Clear wins over push.
module if_inst_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  IfEntry_t               push_data_i,
  output IfEntry_t               head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  IfEntry_t        mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A pop on a full buffer frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; clear empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cpu_if_fetch.sv
// cpu_if_fetch: TrivialMIPS instruction-fetch stage. Owns the fetch PC,
// issues one-at-a-time requests on the imem bus and buffers returned words
// for decode. Optional feature macro: CPU_IF_ALIGN_CHECK_EN (misaligned PC
// produces an address-error entry and halts fetch until the next flush).
module cpu_if_fetch
  import cpu_defs::*;
#(
  parameter InstAddr_t RESET_PC   = RESET_PC_DEFAULT,
  parameter int        FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  InstAddr_t             redirect_pc,
  cpu_if_fetch_if.master        imem,
  output logic                  valid_o,
  output InstAddr_t             pc_o,
  output Inst_t                 inst_o,
  output logic                  addr_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  IfState_t    state_q;
  InstAddr_t   pc_fetch_q;
  logic        imem_req_q;
  InstAddr_t   imem_addr_q;

  InstAddr_t   fetch_addr;
  logic        issue_ok;
  logic        room_after_push;
  logic        fifo_push;
  logic        fifo_pop;
  IfEntry_t    fifo_push_data;
  IfEntry_t    fifo_head;
  logic [CW-1:0] fifo_count;
  logic        fifo_full_unused;
  logic        fifo_empty;

`ifdef CPU_IF_ALIGN_CHECK_EN
  assign fetch_addr = pc_fetch_q;
`else
  assign fetch_addr = {pc_fetch_q[31:2], 2'b00};
`endif

  // Nothing is in flight while IDLE, so occupancy is just the buffer count.
  assign issue_ok        = (fifo_count < CW'(FIFO_DEPTH));
  // On the response cycle the pushed word already counts toward occupancy.
  assign room_after_push = (fifo_count < CW'(FIFO_DEPTH - 1));

  assign fifo_pop = valid_o & ~stall;

  // Select what (if anything) enters the buffer this cycle; flush discards.
  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = '{pc: fetch_addr, inst: imem.imem_rdata, addr_err: 1'b0};
    if (!flush && state_q == IF_WAIT && imem.imem_rvalid) begin
      fifo_push = 1'b1;
    end
`ifdef CPU_IF_ALIGN_CHECK_EN
    if (!flush && state_q == IF_IDLE && issue_ok && fetch_addr[1:0] != 2'b00) begin
      fifo_push               = 1'b1;
      fifo_push_data.inst     = '0;
      fifo_push_data.addr_err = 1'b1;
    end
`endif
  end

  // Fetch FSM with registered bus outputs. A response returns the FSM to
  // IDLE, and IDLE's issue check is applied in that same cycle so a new
  // request can go out back-to-back (one instruction every two cycles).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      pc_fetch_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else if (flush) begin
`ifdef CPU_IF_ALIGN_CHECK_EN
      pc_fetch_q <= redirect_pc;
`else
      pc_fetch_q <= {redirect_pc[31:2], 2'b00};
`endif
      imem_req_q <= 1'b0;
      case (state_q)
        IF_REQ:  state_q <= imem.imem_gnt    ? IF_DROP : IF_IDLE;
        IF_WAIT: state_q <= imem.imem_rvalid ? IF_IDLE : IF_DROP;
        IF_DROP: state_q <= imem.imem_rvalid ? IF_IDLE : IF_DROP;
        default: state_q <= IF_IDLE;
      endcase
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (issue_ok) begin
`ifdef CPU_IF_ALIGN_CHECK_EN
            if (fetch_addr[1:0] != 2'b00) begin
              state_q <= IF_HALT;
            end else begin
              state_q     <= IF_REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= fetch_addr;
            end
`else
            state_q     <= IF_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_addr;
`endif
          end
        end
        IF_REQ: begin
          if (imem.imem_gnt) begin
            state_q    <= IF_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        IF_WAIT: begin
          if (imem.imem_rvalid) begin
            pc_fetch_q <= pc_next(pc_fetch_q);
            if (room_after_push) begin
              state_q     <= IF_REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_next(fetch_addr);
            end else begin
              state_q <= IF_IDLE;
            end
          end
        end
        IF_DROP: begin
          if (imem.imem_rvalid) state_q <= IF_IDLE;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .push_data_i (fifo_push_data),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty)
  );

  assign valid_o = ~fifo_empty;
  assign pc_o    = valid_o ? fifo_head.pc   : '0;
  assign inst_o  = valid_o ? fifo_head.inst : '0;

`ifdef CPU_IF_ALIGN_CHECK_EN
  assign addr_err_o = valid_o & fifo_head.addr_err;
`else
  logic addr_err_unused;
  assign addr_err_unused = fifo_head.addr_err;
  assign addr_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_if_fetch.sv
// Testbench for cpu_if_fetch: directed scenarios plus a randomized run
// checked against a stream-level model (delivered PCs are consecutive words
// from the last redirect, each paired with the memory's word at that PC).
module tb_cpu_if_fetch;
  import cpu_defs::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        addr_err_o;

  cpu_if_fetch_if bus();

  cpu_if_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .valid_o     (valid_o),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .addr_err_o  (addr_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  // Memory slave model and expected-stream state.
  bit          mem_busy;
  logic [31:0] mem_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    step(); step();
    rst = 1'b0;
    mem_busy = 1'b0; mem_addr = '0; exp_pc = RST_PC; exp_fetch = RST_PC;
  endtask

  // One clock of the memory slave with random grant/response, plus model update.
  task automatic mem_cycle(input int gnt_pct, input int rv_pct);
    logic s_req, s_valid, s_stall, s_flush, g, r;
    logic [31:0] s_addr, s_redir;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = valid_o;
    s_stall = stall; s_flush = flush; s_redir = redirect_pc;
    g = s_req && !mem_busy && ($urandom_range(99) < gnt_pct);
    r = mem_busy && ($urandom_range(99) < rv_pct);
    bus.imem_gnt = g; bus.imem_rvalid = r;
    bus.imem_rdata = r ? mem_fn(mem_addr) : $urandom();
    if (s_valid && !s_stall && !s_flush) $display("pop pc=%h inst=%h", pc_o, inst_o);
    step();
    if (r) mem_busy = 1'b0;
    if (g) begin mem_busy = 1'b1; mem_addr = s_addr; end
    if (s_flush) begin
      exp_pc = s_redir; exp_fetch = s_redir;
    end else begin
      if (s_valid && !s_stall) begin exp_pc = exp_pc + 32'd4; pops++; end
      if (g) exp_fetch = exp_fetch + 32'd4;
    end
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    step(); step(); step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", bus.imem_addr, RST_PC); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
    checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", addr_err_o); end
    rst = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", bus.imem_req); end
    $display("reset done req=%b addr=%h", bus.imem_req, bus.imem_addr);
  endtask

  task automatic test_first_fetch();
    do_reset();
    step();
    checks++; if (bus.imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ff_addr0: got %h expected bfc00000", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2408_0001;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ff_early_valid: got %b expected 0", valid_o); end
    step();
    bus.imem_rvalid = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b expected 1", valid_o); end
    checks++; if (pc_o !== 32'hBFC0_0000) begin errors++; $display("FAIL ff_pc: got %h expected bfc00000", pc_o); end
    checks++; if (inst_o !== 32'h2408_0001) begin errors++; $display("FAIL ff_inst: got %h expected 24080001", inst_o); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL ff_addr1: got req=%b addr=%h expected req=1 addr=bfc00004", bus.imem_req, bus.imem_addr); end
    $display("first fetch pc=%h inst=%h next=%h", pc_o, inst_o, bus.imem_addr);
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n >= 5) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d: got %b expected 0", n, bus.imem_req); end
      end
      mem_cycle(100, 100);
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (valid_o !== 1'b1 || pc_o !== RST_PC + 32'(4 * k)) begin errors++; $display("FAIL stall_pc%0d: got v=%b pc=%h expected v=1 pc=%h", k, valid_o, pc_o, RST_PC + 32'(4 * k)); end
      checks++; if (inst_o !== mem_fn(RST_PC + 32'(4 * k))) begin errors++; $display("FAIL stall_inst%0d: got %h expected %h", k, inst_o, mem_fn(RST_PC + 32'(4 * k))); end
      mem_cycle(0, 0);
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_extra: got valid %b expected 0", valid_o); end
  endtask

  task automatic test_flush_wait();
    do_reset();
    step();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0; flush = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    flush = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    checks++; if (valid_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL fw_stale: got v=%b inst=%h expected v=0 inst=0", valid_o, inst_o); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL fw_redirect: got req=%b addr=%h expected req=1 addr=80000100", bus.imem_req, bus.imem_addr); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fw_valid: got %b expected 0", valid_o); end
    $display("flush in wait: next addr=%h", bus.imem_addr);
  endtask

  task automatic test_flush_rvalid();
    do_reset();
    stall = 1'b1;
    step();
    bus.imem_gnt = 1'b1; step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_1111; step();
    bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1; step();
    bus.imem_gnt = 1'b0;
    checks++; if (valid_o !== 1'b1 || pc_o !== RST_PC) begin errors++; $display("FAIL fr_pre: got v=%b pc=%h expected v=1 pc=%h", valid_o, pc_o, RST_PC); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222;
    flush = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    bus.imem_rvalid = 1'b0; flush = 1'b0; stall = 1'b0;
    checks++; if (valid_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL fr_empty: got v=%b inst=%h expected v=0 inst=0", valid_o, inst_o); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL fr_req: got req=%b addr=%h expected req=1 addr=80000200", bus.imem_req, bus.imem_addr); end
    bus.imem_gnt = 1'b1; step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h3333_3333; step();
    bus.imem_rvalid = 1'b0;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0200 || inst_o !== 32'h3333_3333) begin errors++; $display("FAIL fr_new: got v=%b pc=%h inst=%h expected v=1 pc=80000200 inst=33333333", valid_o, pc_o, inst_o); end
    $display("flush with rvalid: head pc=%h inst=%h", pc_o, inst_o);
  endtask

  task automatic test_wrap();
    do_reset();
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got req=%b addr=%h expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); end
    bus.imem_gnt = 1'b1; step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_1234; step();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got v=%b pc=%h expected v=1 pc=fffffffc", valid_o, pc_o); end
    $display("wrap: head pc=%h next addr=%h", pc_o, bus.imem_addr);
  endtask

`ifdef CPU_IF_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    flush = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    flush = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL al_req0: got %b expected 0", bus.imem_req); end
    step();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0102 || addr_err_o !== 1'b1 || inst_o !== 32'h0) begin errors++; $display("FAIL al_entry: got v=%b pc=%h err=%b inst=%h expected 1 80000102 1 0", valid_o, pc_o, addr_err_o, inst_o); end
    for (int n = 0; n < 6; n++) begin
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL al_halt c%0d: got %b expected 0", n, bus.imem_req); end
      step();
    end
    flush = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    flush = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL al_resume: got req=%b addr=%h expected req=1 addr=80000200", bus.imem_req, bus.imem_addr); end
  endtask
`endif

  task automatic test_random();
    bit prev_flush, prev_hold;
    logic [31:0] prev_addr, r32;
    logic s_req;
    do_reset();
    pops = 0; prev_flush = 1'b0; prev_hold = 1'b0; prev_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      if (prev_flush) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rnd_flush_valid c%0d: got %b expected 0", n, valid_o); end
      end
      if (valid_o === 1'b1) begin
        checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h expected %h", n, pc_o, exp_pc); end
        checks++; if (inst_o !== mem_fn(exp_pc)) begin errors++; $display("FAIL rnd_inst c%0d: got %h expected %h", n, inst_o, mem_fn(exp_pc)); end
      end else begin
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rnd_inst_idle c%0d: got %h expected 0", n, inst_o); end
      end
      checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL rnd_err c%0d: got %b expected 0", n, addr_err_o); end
      if (bus.imem_req === 1'b1) begin
        checks++; if (bus.imem_addr !== exp_fetch) begin errors++; $display("FAIL rnd_addr c%0d: got %h expected %h", n, bus.imem_addr, exp_fetch); end
        checks++; if (mem_busy) begin errors++; $display("FAIL rnd_outstanding c%0d: got req with busy=1 expected no req", n); end
      end
      if (prev_hold) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c%0d: got req=%b addr=%h expected req=1 addr=%h", n, bus.imem_req, bus.imem_addr, prev_addr); end
      end
      stall = ($urandom_range(99) < 35);
      flush = ($urandom_range(99) < 3);
      r32 = $urandom();
      redirect_pc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : {r32[31:2], 2'b00};
      s_req = bus.imem_req; prev_addr = bus.imem_addr;
      mem_cycle(60, 50);
      prev_hold  = s_req && !bus_granted_last() && !flush;
      prev_flush = flush;
    end
    flush = 1'b0; stall = 1'b0;
    checks++; if (pops < 200) begin errors++; $display("FAIL rnd_progress: got %0d pops expected at least 200", pops); end
  endtask

  // After mem_cycle a grant leaves the model busy with the sampled address.
  logic [31:0] last_busy_addr;
  function automatic bit bus_granted_last();
    return mem_busy && (mem_addr == last_busy_addr_q());
  endfunction
  function automatic logic [31:0] last_busy_addr_q();
    return tb_cpu_if_fetch.prev_grant_addr;
  endfunction
  logic [31:0] prev_grant_addr;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    prev_grant_addr = '0; last_busy_addr = '0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_flush_wait();
    test_flush_rvalid();
    test_wrap();
`ifdef CPU_IF_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Tracks the address of the most recent grant so the hold check can tell
  // a granted request from one still waiting.
  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_gnt) prev_grant_addr <= bus.imem_addr;
  end

endmodule
